// File: rtl/bcd_stopwatch_core.sv
// Packed-BCD stopwatch/timer core: up/down counting, pause/resume, lap capture,
// terminal-count done flag with optional wrap to the start value.
module bcd_stopwatch_core #(
  parameter int NUM_DIGITS  = 4,
  parameter int WRAP_AT_END = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    startstop,
  input  logic                    clear,
  input  logic                    lap,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] preload,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [4*NUM_DIGITS-1:0] lap_digits,
  output logic                    lap_valid,
  output logic                    running,
  output logic                    done,
  output logic                    done_pulse
);
  localparam int W = 4 * NUM_DIGITS;

  // IDLE: track start value | RUN: count on tick | PAUSE: hold | DONE: hold at terminal
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic [W-1:0]   lap_q, lap_d;
  logic [W-1:0]   pre_q, pre_d;
  logic [1:0]     mode_q, mode_d;
  logic           lap_valid_q, lap_valid_d;
  logic           done_pulse_q, done_pulse_d;
  logic           ss_ff_q;
  logic           ss_edge;
  logic [W-1:0]   pre_clamped, start_now, start_frozen, term_now, term_q, stepped;

  function automatic logic [W-1:0] all_nines();
    logic [W-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] p);
    logic [W-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[4*i +: 4] = (p[4*i +: 4] > 4'd9) ? 4'd9 : p[4*i +: 4];
    return r;
  endfunction

  function automatic logic [W-1:0] start_val(input logic [1:0] m, input logic [W-1:0] pc);
    case (m)
      2'b00:   return '0;
      2'b10:   return all_nines();
      default: return pc;
    endcase
  endfunction

  function automatic logic [W-1:0] terminal(input logic down);
    return down ? '0 : all_nines();
  endfunction

  // Ripple carry/borrow starting at digit 0; each digit stays within 0..9.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (down) begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  assign ss_edge      = ss_ff_q & ~startstop;
  assign pre_clamped  = clamp_bcd(preload);
  assign start_now    = start_val(mode, pre_clamped);
  assign start_frozen = start_val(mode_q, pre_q);
  assign term_now     = terminal(mode[1]);
  assign term_q       = terminal(mode_q[1]);
  assign stepped      = bcd_step(digits_q, mode_q[1]);

  always_comb begin
    state_d      = state_q;
    digits_d     = digits_q;
    lap_d        = lap_q;
    lap_valid_d  = lap_valid_q;
    mode_d       = mode_q;
    pre_d        = pre_q;
    done_pulse_d = 1'b0;
    if (clear) begin
      state_d     = S_IDLE;
      digits_d    = start_now;
      mode_d      = mode;
      pre_d       = pre_clamped;
      lap_valid_d = 1'b0;
    end else begin
      if (lap && state_q != S_IDLE) begin
        lap_d       = digits_q;
        lap_valid_d = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          digits_d = start_now;
          mode_d   = mode;
          pre_d    = pre_clamped;
          if (ss_edge) begin
            if (start_now == term_now) begin
              state_d      = S_DONE;
              done_pulse_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            if (WRAP_AT_END != 0 && digits_q == term_q) begin
              digits_d     = start_frozen;
              done_pulse_d = 1'b1;
            end else begin
              digits_d = stepped;
              if (WRAP_AT_END == 0 && stepped == term_q) begin
                state_d      = S_DONE;
                done_pulse_d = 1'b1;
              end
            end
          end
          if (ss_edge && state_d == S_RUN) state_d = S_PAUSE;
        end
        S_PAUSE: if (ss_edge) state_d = S_RUN;
        S_DONE:  ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      digits_q     <= '0;
      lap_q        <= '0;
      pre_q        <= '0;
      mode_q       <= 2'b00;
      lap_valid_q  <= 1'b0;
      done_pulse_q <= 1'b0;
      ss_ff_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      lap_q        <= lap_d;
      pre_q        <= pre_d;
      mode_q       <= mode_d;
      lap_valid_q  <= lap_valid_d;
      done_pulse_q <= done_pulse_d;
      ss_ff_q      <= startstop;
    end
  end

  assign digits     = digits_q;
  assign lap_digits = lap_q;
  assign lap_valid  = lap_valid_q;
  assign done_pulse = done_pulse_q;
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Bench for bcd_stopwatch_core: two instances (stop-at-end and wrap) share stimulus and
// are compared every cycle against an integer-valued stopwatch model.
module tb_bcd_stopwatch_core;
  localparam int N    = 4;
  localparam int W    = 4 * N;
  localparam int MAXV = 9999;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tick = 1'b0, startstop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] preload = '0;
  logic [W-1:0] dig [2];
  logic [W-1:0] lapd [2];
  logic         lapv [2], run [2], dn [2], dp [2];

  int n_tests = 0;
  int n_fail  = 0;

  // model state, one slot per instance (0: stop at end, 1: wrap)
  int m_state [2], m_v [2], m_lapd [2], m_start [2];
  bit m_lapv [2], m_pulse [2], m_down [2], m_ssff [2];

  bcd_stopwatch_core #(.NUM_DIGITS(N), .WRAP_AT_END(0)) u_stop (
    .clk(clk), .reset_n(reset_n), .tick(tick), .startstop(startstop), .clear(clear),
    .lap(lap), .mode(mode), .preload(preload), .digits(dig[0]), .lap_digits(lapd[0]),
    .lap_valid(lapv[0]), .running(run[0]), .done(dn[0]), .done_pulse(dp[0]));

  bcd_stopwatch_core #(.NUM_DIGITS(N), .WRAP_AT_END(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .tick(tick), .startstop(startstop), .clear(clear),
    .lap(lap), .mode(mode), .preload(preload), .digits(dig[1]), .lap_digits(lapd[1]),
    .lap_valid(lapv[1]), .running(run[1]), .done(dn[1]), .done_pulse(dp[1]));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int start_of(input logic [1:0] m, input logic [W-1:0] p);
    int v, sc, d;
    v = 0;
    sc = 1;
    for (int i = 0; i < N; i++) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * sc;
      sc *= 10;
    end
    if (m == 2'b00) return 0;
    if (m == 2'b10) return MAXV;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_state[w] = M_IDLE; m_v[w] = 0; m_lapd[w] = 0; m_start[w] = 0;
      m_lapv[w] = 0; m_pulse[w] = 0; m_down[w] = 0; m_ssff[w] = 0;
    end
  endtask

  task automatic model_step(input int w);
    bit edge_seen;
    int term, sv;
    edge_seen = m_ssff[w] && !startstop;
    m_ssff[w] = startstop;
    m_pulse[w] = 0;
    sv = start_of(mode, preload);
    if (clear) begin
      m_state[w] = M_IDLE; m_v[w] = sv; m_lapv[w] = 0;
      m_start[w] = sv; m_down[w] = mode[1];
      return;
    end
    if (lap && m_state[w] != M_IDLE) begin
      m_lapd[w] = m_v[w];
      m_lapv[w] = 1;
    end
    case (m_state[w])
      M_IDLE: begin
        m_v[w] = sv; m_start[w] = sv; m_down[w] = mode[1];
        term = mode[1] ? 0 : MAXV;
        if (edge_seen) begin
          if (sv == term) begin m_state[w] = M_DONE; m_pulse[w] = 1; end
          else m_state[w] = M_RUN;
        end
      end
      M_RUN: begin
        term = m_down[w] ? 0 : MAXV;
        if (tick) begin
          if (m_v[w] == term) begin
            m_v[w] = m_start[w];
            m_pulse[w] = 1;
          end else begin
            m_v[w] = m_down[w] ? m_v[w] - 1 : m_v[w] + 1;
            if (w == 0 && m_v[w] == term) begin m_state[w] = M_DONE; m_pulse[w] = 1; end
          end
        end
        if (edge_seen && m_state[w] == M_RUN) m_state[w] = M_PAUSE;
      end
      M_PAUSE: if (edge_seen) m_state[w] = M_RUN;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("digits[%0d]", w), 32'(dig[w]), 32'(to_bcd(m_v[w])));
      chk($sformatf("lap_digits[%0d]", w), 32'(lapd[w]), 32'(to_bcd(m_lapd[w])));
      chk($sformatf("lap_valid[%0d]", w), 32'(lapv[w]), 32'(m_lapv[w]));
      chk($sformatf("running[%0d]", w), 32'(run[w]), 32'(m_state[w] == M_RUN));
      chk($sformatf("done[%0d]", w), 32'(dn[w]), 32'(m_state[w] == M_DONE));
      chk($sformatf("done_pulse[%0d]", w), 32'(dp[w]), 32'(m_pulse[w]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cycle();
    tick = 1'b0;
  endtask

  task automatic press();
    startstop = 1'b1; cycle();
    startstop = 1'b0; cycle();
  endtask

  task automatic do_clear(input logic [1:0] m, input logic [W-1:0] p);
    mode = m; preload = p; clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int w = 0; w < 2; w++)
      chk($sformatf("%s[%0d]", tag, w),
          {dig[w], lapd[w]} | 32'({lapv[w], run[w], dn[w], dp[w]}), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    reset_n = 1'b1;

    // T1: up from 0 to 9999
    do_clear(2'b00, '0);
    press();
    ticks(10005);
    chk("t1_digits", 32'(dig[0]), 32'h9999);
    chk("t1_done", 32'(dn[0]), 32'd1);

    // T2: clamped preload counting down
    do_clear(2'b11, 16'h001F);
    cycle();
    chk("t2_clamp", 32'(dig[0]), 32'h0019);
    press();
    ticks(19);
    chk("t2_zero", 32'(dig[0]), 32'h0000);
    chk("t2_done", 32'(dn[0]), 32'd1);

    // T3: ripple carry
    do_clear(2'b01, 16'h0099);
    cycle();
    chk("t3_pre", 32'(dig[0]), 32'h0099);
    press();
    ticks(1);
    chk("t3_carry", 32'(dig[0]), 32'h0100);

    // T4: stop edge with coincident tick, pause, resume
    do_clear(2'b00, '0);
    press();
    ticks(41);
    tick = 1'b1; startstop = 1'b1; cycle();
    startstop = 1'b0; cycle(); tick = 1'b0;
    chk("t4_pause_val", 32'(dig[0]), 32'h0043);
    chk("t4_paused", 32'(run[0]), 32'd0);
    ticks(5);
    chk("t4_hold", 32'(dig[0]), 32'h0043);
    press();
    ticks(1);
    chk("t4_resume", 32'(dig[0]), 32'h0044);

    // T5: lap capture, then clear+lap
    do_clear(2'b01, 16'h0123);
    press();
    lap = 1'b1; cycle(); lap = 1'b0;
    chk("t5_lap", 32'(lapd[0]), 32'h0123);
    chk("t5_lapv", 32'(lapv[0]), 32'd1);
    ticks(3);
    lap = 1'b1; clear = 1'b1; cycle(); lap = 1'b0; clear = 1'b0;
    chk("t5_lapv_clr", 32'(lapv[0]), 32'd0);
    chk("t5_lap_hold", 32'(lapd[0]), 32'h0123);

    // T6: wrap from 0000 back to 9999, then async reset mid-run
    do_clear(2'b10, '0);
    press();
    ticks(9999);
    chk("t6_zero", 32'(dig[1]), 32'h0000);
    ticks(1);
    chk("t6_wrap", 32'(dig[1]), 32'h9999);
    chk("t6_pulse", 32'(dp[1]), 32'd1);
    chk("t6_running", 32'(run[1]), 32'd1);
    ticks(7);
    lap = 1'b1; cycle(); lap = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // randomized operation
    do_clear(2'b00, '0);
    for (int c = 0; c < 30000; c++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) startstop = ~startstop;
      lap = ($urandom_range(0, 29) == 0);
      clear = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 49) == 0) begin
        mode = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0: preload = 16'h9990 | 16'($urandom_range(0, 15));
          1: preload = 16'($urandom_range(0, 31));
          default: preload = 16'($urandom);
        endcase
      end
      cycle();
    end
    tick = 1'b0; lap = 1'b0; clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
